// File: rtl/prefix_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with NZCV flags; optional saturation under PREFIX_ADDSUB_SAT_EN.
// Latency STAGES+1 cycles from accept to out_valid when unstalled; throughput 1 beat/cycle.
// Backpressure: out_ready ripples combinationally to in_ready; bubbles collapse, a stalled output holds s/flags.
module prefix_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    // prefix levels in the tree, and register count: stage 0, STAGES tree levels, output
    localparam int LOG  = $clog2(WIDTH);
    localparam int NREG = STAGES + 2;
    localparam int DIV  = (STAGES == 0) ? 1 : STAGES;

    // Operand beat in generate/propagate form. g/p are group values refined level by level;
    // x keeps the per-bit propagate for the final sum. The carry-in is folded into g[0].
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] x;
        logic             a_msb;
        logic             b_msb;
        logic             cin;
`ifdef PREFIX_ADDSUB_SAT_EN
        logic             sat;
`endif
    } pp_t;

    // First prefix level handled by pipeline segment j (segment j ends in register level j)
    function automatic int lvl_bound(input int j);
        return (STAGES == 0) ? 0 : (j * LOG) / DIV;
    endfunction

    // Apply Kogge-Stone levels [lo, hi) to a beat; level l combines with the group 2^l below
    function automatic pp_t ks_span(input pp_t d, input int lo, input int hi);
        pp_t              r;
        logic [WIDTH-1:0] g_prev;
        logic [WIDTH-1:0] p_prev;
        r = d;
        for (int l = 0; l < LOG; l++) begin
            if (l >= lo && l < hi) begin
                g_prev = r.g;
                p_prev = r.p;
                for (int i = (1 << l); i < WIDTH; i++) begin
                    r.g[i] = g_prev[i] | (p_prev[i] & g_prev[i - (1 << l)]);
                    r.p[i] = p_prev[i] & p_prev[i - (1 << l)];
                end
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] w_bp;
    pp_t              w_in;
    pp_t              w_nxt [0:STAGES];
    pp_t              r_stg [0:STAGES];
    pp_t              w_fin;
    logic [NREG-1:0]  r_vld;
    logic [NREG-1:0]  w_free;
    logic [NREG-1:0]  w_vld_src;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_unused;

    logic [WIDTH-1:0] r_s;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             r_v;

    // Operand conditioning: invert b for subtract, fold carry-in into bit 0's generate
    always_comb begin
        w_bp       = sub ? ~b : b;
        w_in       = '0;
        w_in.g     = a & w_bp;
        w_in.p     = a ^ w_bp;
        w_in.x     = a ^ w_bp;
        w_in.g[0]  = (a[0] & w_bp[0]) | ((a[0] ^ w_bp[0]) & sub);
        w_in.a_msb = a[WIDTH-1];
        w_in.b_msb = w_bp[WIDTH-1];
        w_in.cin   = sub;
`ifdef PREFIX_ADDSUB_SAT_EN
        w_in.sat   = sat;
`endif
    end

    genvar gj;
    generate
        for (gj = 0; gj <= STAGES; gj++) begin : g_seg
            if (gj == 0) begin : g_first
                assign w_nxt[gj] = w_in;
            end else begin : g_level
                assign w_nxt[gj] = ks_span(r_stg[gj-1], lvl_bound(gj-1), lvl_bound(gj));
            end
        end
    endgenerate

    // Whatever prefix levels remain after the last register level are done before the output register
    assign w_fin = ks_span(r_stg[STAGES], lvl_bound(STAGES), LOG);

    // Sum and raw carry/overflow; carry into bit i is the group generate of bits i-1..0
    always_comb begin
        w_raw = w_fin.x ^ {w_fin.g[WIDTH-2:0], w_fin.cin};
        w_c   = w_fin.g[WIDTH-1];
        w_v   = (w_fin.a_msb == w_fin.b_msb) && (w_raw[WIDTH-1] != w_fin.a_msb);
`ifdef PREFIX_ADDSUB_SAT_EN
        // clamp toward the sign of the operands: wrapped negative -> max positive, wrapped positive -> min negative
        if (w_fin.sat && w_v)
            w_res = w_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        else
            w_res = w_raw;
`else
        w_res = w_raw;
`endif
    end

`ifdef PREFIX_ADDSUB_SAT_EN
    assign w_unused = ^w_fin.p;
`else
    assign w_unused = ^{w_fin.p, sat};
`endif

    // Free chain: a stage may load if empty or if the stage after it is moving this cycle
    always_comb begin : free_chain
        logic v_f;
        v_f = out_ready;
        w_free = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            v_f       = !r_vld[i] || v_f;
            w_free[i] = v_f;
        end
    end

    assign w_vld_src = {r_vld[NREG-2:0], in_valid};
    assign in_ready  = w_free[0];

    // Valid bits: each stage takes its predecessor's valid whenever it is free to load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (w_free[i]) r_vld[i] <= w_vld_src[i];
        end
    end

    // Datapath registers: only loaded with a real beat, contents are don't-care while invalid
    always_ff @(posedge clk) begin
        for (int i = 0; i <= STAGES; i++)
            if (w_free[i] && w_vld_src[i]) r_stg[i] <= w_nxt[i];
    end

    // Output register: holds result and flags stable while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s <= '0;
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else if (w_free[NREG-1] && w_vld_src[NREG-1]) begin
            r_s <= w_res;
            r_n <= w_res[WIDTH-1];
            r_z <= ~|w_res;
            r_c <= w_c;
            r_v <= w_v;
        end
    end

    assign out_valid = r_vld[NREG-1];
    assign s         = r_s;
    assign flag_n    = r_n;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign flag_v    = r_v;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Self-checking bench: table vectors on a 32-bit/2-stage instance, hand sequences for
// backpressure and mid-flight reset, random scoreboard sweeps on 8-bit instances (STAGES 0 and 3).
module tb_prefix_addsub_pipe;

`ifdef PREFIX_ADDSUB_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic        in_valid32, in_ready32, sub32, sat32, out_valid32, out_ready32;
    logic        n32, z32, c32, v32;
    logic [31:0] a32, b32, s32;

    logic        in_valid8, out_ready8, sub8, sat8;
    logic [7:0]  a8, b8;
    logic        in_ready8a, out_valid8a, n8a, z8a, c8a, v8a;
    logic        in_ready8b, out_valid8b, n8b, z8b, c8b, v8b;
    logic [7:0]  s8a, s8b;

    prefix_addsub_pipe #(.WIDTH(32), .STAGES(2)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sub(sub32), .sat(sat32), .out_valid(out_valid32), .out_ready(out_ready32),
        .s(s32), .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32));

    prefix_addsub_pipe #(.WIDTH(8), .STAGES(0)) u_dut8a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8a),
        .a(a8), .b(b8), .sub(sub8), .sat(sat8), .out_valid(out_valid8a), .out_ready(out_ready8),
        .s(s8a), .flag_n(n8a), .flag_z(z8a), .flag_c(c8a), .flag_v(v8a));

    prefix_addsub_pipe #(.WIDTH(8), .STAGES(3)) u_dut8b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8b),
        .a(a8), .b(b8), .sub(sub8), .sat(sat8), .out_valid(out_valid8b), .out_ready(out_ready8),
        .s(s8b), .flag_n(n8b), .flag_z(z8b), .flag_c(c8b), .flag_v(v8b));

    typedef struct {
        logic [31:0] s;
        logic        n, z, c, v;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        logic [31:0] a, b;
        logic        sub, sat;
        logic [31:0] s;
        logic        n, z, c, v;
    } vec_t;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   acc8a = 0;
    int   acc8b = 0;
    exp_t sb32[$];
    exp_t sb8a[$];
    exp_t sb8b[$];
    exp_t drv_exp;
    exp_t e32, p32, e8a, p8a, e8b, p8b;
    bit   lat32_en = 1'b0;
    bit   lat8_en = 1'b0;
    vec_t tbl[14];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic vec_t mkvec(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                   input logic sat, input logic [31:0] s, input logic n,
                                   input logic z, input logic c, input logic v);
        vec_t r;
        r.a = a; r.b = b; r.sub = sub; r.sat = sat;
        r.s = s; r.n = n; r.z = z; r.c = c; r.v = v;
        return r;
    endfunction

    // Reference arithmetic on plain integers, masked to w bits
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic sat);
        exp_t        e;
        logic [32:0] mask, bb, full;
        mask = (33'd1 << w) - 33'd1;
        bb   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full = ({1'b0, a} & mask) + bb + {32'd0, sub};
        e.s  = full[31:0] & mask[31:0];
        e.c  = full[w];
        e.v  = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
        if (SAT_ON && sat && e.v)
            e.s = a[w-1] ? (32'd1 << (w-1)) : (mask[31:0] >> 1);
        e.n = e.s[w-1];
        e.z = (e.s == 32'd0);
        e.cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // 32-bit scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid32 && in_ready32) begin
                e32 = drv_exp;
                e32.cyc = cyc;
                sb32.push_back(e32);
            end
            if (out_valid32 && out_ready32) begin
                if (sb32.size() == 0) begin
                    check("out32_spurious", 1, 0);
                end else begin
                    p32 = sb32.pop_front();
                    check("out32_data", {s32, n32, z32, c32, v32}, {p32.s, p32.n, p32.z, p32.c, p32.v});
                    if (p32.chk_lat) check("out32_latency", cyc - p32.cyc - 1, 3);
                end
            end
        end
    end

    // 8-bit STAGES=0 scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid8 && in_ready8a) begin
                e8a = model(8, {24'd0, a8}, {24'd0, b8}, sub8, sat8);
                e8a.cyc = cyc;
                e8a.chk_lat = lat8_en;
                sb8a.push_back(e8a);
                acc8a++;
            end
            if (out_valid8a && out_ready8) begin
                if (sb8a.size() == 0) begin
                    check("out8a_spurious", 1, 0);
                end else begin
                    p8a = sb8a.pop_front();
                    check("out8a_data", {s8a, n8a, z8a, c8a, v8a}, {p8a.s[7:0], p8a.n, p8a.z, p8a.c, p8a.v});
                    if (p8a.chk_lat) check("out8a_latency", cyc - p8a.cyc - 1, 1);
                end
            end
        end
    end

    // 8-bit STAGES=3 scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid8 && in_ready8b) begin
                e8b = model(8, {24'd0, a8}, {24'd0, b8}, sub8, sat8);
                e8b.cyc = cyc;
                e8b.chk_lat = lat8_en;
                sb8b.push_back(e8b);
                acc8b++;
            end
            if (out_valid8b && out_ready8) begin
                if (sb8b.size() == 0) begin
                    check("out8b_spurious", 1, 0);
                end else begin
                    p8b = sb8b.pop_front();
                    check("out8b_data", {s8b, n8b, z8b, c8b, v8b}, {p8b.s[7:0], p8b.n, p8b.z, p8b.c, p8b.v});
                    if (p8b.chk_lat) check("out8b_latency", cyc - p8b.cyc - 1, 4);
                end
            end
        end
    end

    // Present one beat (called just after a rising edge); returns just after the accepting edge
    task automatic send32(input vec_t v);
        bit got;
        a32 = v.a; b32 = v.b; sub32 = v.sub; sat32 = v.sat;
        drv_exp.s = v.s; drv_exp.n = v.n; drv_exp.z = v.z; drv_exp.c = v.c; drv_exp.v = v.v;
        drv_exp.cyc = 0; drv_exp.chk_lat = lat32_en;
        in_valid32 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready32) begin
                got = 1'b1;
                break;
            end
        end
        check("send32_accept", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain32();
        for (int i = 0; i < 100; i++) begin
            if (sb32.size() == 0) break;
            @(negedge clk);
        end
        check("drain32_empty", sb32.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand8();
        a8 = 8'($urandom); b8 = 8'($urandom);
        sub8 = 1'($urandom); sat8 = 1'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        int cycles;
        tbl[0]  = mkvec(32'd980, 32'd722, 1, 0, 32'd258, 0, 0, 1, 0);
        tbl[1]  = mkvec(32'd0, 32'd1, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        tbl[2]  = mkvec(32'd100, 32'd50, 1, 0, 32'd50, 0, 0, 1, 0);
        tbl[3]  = mkvec(32'd10001, 32'd2, 1, 0, 32'd9999, 0, 0, 1, 0);
        tbl[4]  = mkvec(32'hFFFF_FFFF, 32'd5, 1, 0, 32'd4294967290, 1, 0, 1, 0);
        tbl[5]  = mkvec(32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 0, 1, 1, 0);
        tbl[6]  = mkvec(32'h7FFF_FFFF, 32'd1, 0, 0, 32'h8000_0000, 1, 0, 0, 1);
        tbl[7]  = mkvec(32'h8000_0000, 32'd1, 1, 0, 32'h7FFF_FFFF, 0, 0, 1, 1);
        tbl[8]  = mkvec(32'd5, 32'd5, 1, 0, 32'd0, 0, 1, 1, 0);
        tbl[9]  = mkvec(32'd0, 32'd0, 0, 0, 32'd0, 0, 1, 0, 0);
        tbl[10] = mkvec(32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0, 0, 0);
        tbl[11] = mkvec(32'h8000_0000, 32'h8000_0000, 0, 0, 32'd0, 0, 1, 1, 1);
`ifdef PREFIX_ADDSUB_SAT_EN
        tbl[12] = mkvec(32'h7FFF_FFFF, 32'd1, 0, 1, 32'h7FFF_FFFF, 0, 0, 0, 1);
        tbl[13] = mkvec(32'h8000_0000, 32'd1, 1, 1, 32'h8000_0000, 1, 0, 1, 1);
`else
        tbl[12] = mkvec(32'h7FFF_FFFF, 32'd1, 0, 1, 32'h8000_0000, 1, 0, 0, 1);
        tbl[13] = mkvec(32'h8000_0000, 32'd1, 1, 1, 32'h7FFF_FFFF, 0, 0, 1, 1);
`endif

        reset_n = 1'b0;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; sat32 = 1'b0; out_ready32 = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; sat8 = 1'b0; out_ready8 = 1'b1;
        drv_exp = '{s: 32'd0, n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0, cyc: 0, chk_lat: 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid32", out_valid32, 0);
        check("rst_s_flags32", {s32, n32, z32, c32, v32}, 36'd0);
        check("rst_out_valid8", {out_valid8a, out_valid8b}, 2'b00);
        check("rst_s8", {s8a, s8b}, 16'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready32, 1);
        check("out_valid_after_rst", out_valid32, 0);
        @(posedge clk); #1;

        // table vectors, back-to-back, unstalled: latency 3 and one result per cycle
        lat32_en = 1'b1;
        for (int i = 0; i < 14; i++) send32(tbl[i]);
        in_valid32 = 1'b0;
        wait_drain32();

        // backpressure: four beats fill the pipe, output holds, then drains in order
        lat32_en = 1'b0;
        out_ready32 = 1'b0;
        for (int i = 0; i < 4; i++) send32(tbl[i]);
        in_valid32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready32, 0);
            check("bp_hold_first", {out_valid32, s32, c32}, {1'b1, 32'd258, 1'b1});
        end
        @(posedge clk); #1;
        out_ready32 = 1'b1;
        wait_drain32();
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | out_valid32;
        end
        check("bp_no_duplicate", seen, 0);
        @(posedge clk); #1;

        // reset with three beats in flight
        out_ready32 = 1'b0;
        for (int i = 2; i < 5; i++) send32(tbl[i]);
        in_valid32 = 1'b0;
        @(posedge clk); #1;
        check("midrst_pre_valid", out_valid32, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_async_valid", out_valid32, 0);
        check("midrst_async_s", s32, 32'd0);
        sb32.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready32 = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | out_valid32;
        end
        check("midrst_no_stale", seen, 0);
        @(posedge clk); #1;
        lat32_en = 1'b1;
        send32(tbl[3]);
        in_valid32 = 1'b0;
        wait_drain32();

        // 8-bit sweeps: unstalled latency phase, then random valid/ready
        lat8_en = 1'b1;
        out_ready8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_valid8 = 1'b1;
            rand8();
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        lat8_en = 1'b0;
        cycles = 0;
        while ((acc8a < 1030 || acc8b < 1030) && cycles < 20000) begin
            in_valid8 = 1'($urandom);
            out_ready8 = ($urandom_range(3) != 0);
            rand8();
            @(posedge clk); #1;
            cycles++;
        end
        check("rand8a_beats", acc8a >= 1030, 1);
        check("rand8b_beats", acc8b >= 1030, 1);
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (sb8a.size() == 0 && sb8b.size() == 0) break;
            @(negedge clk);
        end
        check("drain8a_empty", sb8a.size(), 0);
        check("drain8b_empty", sb8b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prefix_addsub_pipe.md
Name: prefix_addsub_pipe

Overview:
- Parametrised, pipelined Kogge-Stone prefix adder/subtractor.
- Generalises the fixed 32-bit combinational prefix subtractor in three ways: selectable width, a per-operation add/sub mode, and configurable pipeline depth.
- Uses a valid/ready handshake with backpressure.
- Produces NZCV status flags for use by the datapath ALU and by address-generation logic.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- STAGES, 2, number of pipeline register levels inside the prefix tree (0..clog2(WIDTH)); registers are spread evenly across prefix levels.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b; 1: a-b (computed as a + ~b + 1).
- sat  input  1  saturate request; see Optional Feature.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  result.
- flag_n  output  1  s[WIDTH-1].
- flag_z  output  1  s == 0.
- flag_c  output  1  carry out of the MSB; for sub, 1 means no borrow (a >= b unsigned).
- flag_v  output  1  signed overflow.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all stage valid bits clear, so out_valid=0.
  - s and flags reset to 0.
  - in_ready=1 on the first edge after release.
- Pipeline structure:
  - input register (stage 0, captures a, ~b or b, cin=sub, sat).
  - then STAGES register levels.
  - output register holds s/flags.
- Latency: a beat accepted on edge k appears with out_valid=1 after edge k+STAGES+1, provided no backpressure. STAGES=0 gives latency 1.
- Handshake:
  - A transfer occurs when valid && ready are both high at a rising edge.
  - Each stage i holds valid_i. Stage i loads from i-1 when !valid_i || advance_{i+1}; the output advances when out_ready.
  - Bubbles collapse, so throughput is 1 beat/cycle when out_ready=1.
  - in_ready = !valid_0 || advance_1, i.e. combinational from out_ready through the chain.
  - The output holds s/flags stable while out_valid && !out_ready.
  - in_valid must not depend on in_ready.
- Arithmetic:
  - Generate/propagate from a and b' (b or ~b), with carry-in = sub.
  - Full WIDTH-bit wrap-around: 0-1 yields all-ones with C=0; (2^WIDTH-1)+1 yields 0 with C=1, Z=1.
  - flag_v = (a[MSB]==b'[MSB]) && (s[MSB]!=a[MSB]).
  - Flags are computed from the final (post-saturation) s, except C and V, which reflect the raw sum.
- Simultaneous events:
  - A full pipeline with out_ready=1 accepts a new beat in the same cycle the oldest leaves.
  - With out_ready=0 and the pipeline full, in_ready=0.
- Reset mid-operation: all in-flight beats are discarded with no partial output; operand registers need not be cleared, but valid bits must be.

Optional Feature:
- Macro: PREFIX_ADDSUB_SAT_EN.
- Defined:
  - When the sat bit travelling with a beat is 1 and flag_v=1, s clamps to the signed limit: 0111..1 if the raw sum wrapped negative, 1000..0 if it wrapped positive.
  - flag_v still reports 1.
- Undefined: the sat port is present but ignored, and results always wrap. The saturation mux and the sat pipeline bit must not be synthesised.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1. Send (980,722,sub=1), (0,1,sub=1), (100,50,sub=1), (10001,2,sub=1), (4294967295,5,sub=1) back-to-back. Required results, in order, on consecutive cycles starting 3 cycles after the first accept:
  - 258, C=1.
  - 0xFFFFFFFF, N=1, C=0.
  - 50.
  - 9999.
  - 4294967290, C=1.
- Add wrap: a=0xFFFFFFFF, b=1, sub=0 → s=0, Z=1, C=1, V=0. Then a=0x7FFFFFFF, b=1 → s=0x80000000, N=1, V=1.
- Backpressure:
  - Fill the pipe with 4 beats while out_ready=0 → in_ready drops once all 4 stages are valid; s holds the first result unchanged.
  - Then release out_ready → all 4 results are drained in order with none lost or duplicated.
- Reset mid-flight: assert reset_n=0 with 3 beats in flight for 1 cycle → out_valid=0 immediately (async); no stale beat appears after release.
- PREFIX_ADDSUB_SAT_EN defined, sat=1:
  - 0x7FFFFFFF+1 → 0x7FFFFFFF, V=1.
  - 0x80000000-1 → 0x80000000, V=1.
  - With the macro undefined, the same stimulus gives 0x80000000 and 0x7FFFFFFF respectively.
- Sweep WIDTH=8, STAGES=0 and 3: 1000 random beats with random out_ready → every result matches (a±b) mod 256 against a scoreboard model, and latency is 1 and 4 respectively when unstalled.
